reg_dump_reader: RTL and testbench
==================================

REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter FIRST_REG, default 0: index of the first register read out (0..31).
REQ-002 SHALL have parameter LAST_REG, default 31: index of the last register read out; FIRST_REG <= LAST_REG.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a dump; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of a dump in progress.
REQ-007 SHALL have port rf_read_num  output  5  register-file read address.
REQ-008 SHALL have port rf_read_data  input  64  combinational register-file read data for rf_read_num.
REQ-009 SHALL have port out_valid  output  1  out_data/out_index/out_last are valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-011 SHALL have port out_data  output  64  register value or checksum.
REQ-012 SHALL have port out_index  output  5  register index of the current beat.
REQ-013 SHALL have port out_last  output  1  marks the final beat of a dump.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, SEND and (with the checksum macro) CSUM.
REQ-017 SHALL, in IDLE with start=1, load the index counter with FIRST_REG and go to LOAD.
REQ-018 SHALL drive rf_read_num from the index counter in all states.
REQ-019 SHALL, in LOAD, capture rf_read_data into out_data and the index into out_index at the clock edge, then enter SEND with out_valid=1.
REQ-020 SHALL hold out_valid, out_data, out_index and out_last stable in SEND until the cycle where out_valid and out_ready are both 1.
REQ-021 SHALL, on handshake with index < LAST_REG, increment the index and return to LOAD (one idle cycle per beat).
REQ-022 SHALL, on handshake with index = LAST_REG, go to IDLE and pulse done the next cycle, or enter CSUM when the checksum is enabled.
REQ-023 SHALL assert out_last only on the final beat of the dump.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle with out_valid=0 and no done pulse; abort takes priority over a simultaneous handshake.
REQ-026 SHALL never let the index counter wrap; the FIRST_REG = LAST_REG case produces exactly one register beat.

Reset
REQ-027 SHALL, while reset=0, force IDLE, index=FIRST_REG, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, checksum=0, regardless of clock.
REQ-028 SHALL abandon a dump in progress on reset with no partial beat and no done pulse after release.

Configuration
REQ-029 SHALL, with REG_DUMP_CHECKSUM_EN defined, XOR every accepted register value into a 64-bit accumulator (cleared on start) and send one extra beat from CSUM: out_data=accumulator, out_index=LAST_REG, out_last=1.
REQ-030 SHALL, with REG_DUMP_CHECKSUM_EN defined, deassert out_last on the LAST_REG register beat.
REQ-031 SHALL, without REG_DUMP_CHECKSUM_EN, omit CSUM and the accumulator; out_last is set on the LAST_REG beat.

Structure
REQ-032 SHALL take the FSM state encoding, register-index width (5) and data width (64) from the shared processor package.
REQ-033 SHALL be a single module with no sub-modules.

Verification
REQ-034 SHALL cover: register file preset to reset values 0x0..0x1F, start pulse, out_ready=1 -> 32 beats, out_data=out_index=0..31, out_last on index 31, done one cycle after.
REQ-035 SHALL cover: out_ready toggled pseudo-randomly -> beats never dropped, duplicated or changed while stalled.
REQ-036 SHALL cover: FIRST_REG=5, LAST_REG=5 -> exactly one beat, out_data=0x5, out_last=1.
REQ-037 SHALL cover: abort asserted during the beat for index 10 with out_ready=1 -> IDLE next cycle, no done pulse; a new start then begins at index 0.
REQ-038 SHALL cover: reset asserted mid-dump, asynchronously between clock edges -> all outputs zero immediately; start during SEND ignored.
REQ-039 SHALL cover: with REG_DUMP_CHECKSUM_EN and reset values -> 33 beats, final out_data=0x0 (XOR of 0..31), out_last only on the 33rd beat.

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// rtl/reg_dump_reader_pkg.sv - shared processor types: dump FSM encoding, register index and data widths
package reg_dump_reader_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 64;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    CSUM = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - streams register file FIRST_REG..LAST_REG out as valid/ready beats
// REG_DUMP_CHECKSUM_EN adds a trailing XOR-checksum beat
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [REG_W-1:0]  rf_read_num,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam reg_idx_t FIRST_IDX = reg_idx_t'(FIRST_REG);
  localparam reg_idx_t LAST_IDX  = reg_idx_t'(LAST_REG);

  dump_state_t state, state_nxt;
  reg_idx_t    idx;
  logic        handshake;
  logic        is_last;

`ifdef REG_DUMP_CHECKSUM_EN
  data_t       checksum;
`endif

  assign handshake   = out_valid & out_ready;
  assign is_last     = (idx == LAST_IDX);
  assign rf_read_num = idx;
  assign busy        = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = abort ? IDLE : SEND;
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (handshake) begin
          if (!is_last) begin
            state_nxt = LOAD;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = IDLE;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: if (abort || handshake) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Abort is evaluated before the handshake so a cancelled beat never counts as delivered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx       <= FIRST_IDX;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx <= FIRST_IDX;
`ifdef REG_DUMP_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        LOAD: begin
          if (!abort) begin
            out_data  <= rf_read_data;
            out_index <= idx;
            out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            out_last  <= 1'b0;
`else
            out_last  <= is_last;
`endif
          end
        end
        SEND: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            checksum  <= checksum ^ out_data;
`endif
            if (!is_last) begin
              idx <= idx + reg_idx_t'(1);
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              out_data  <= checksum ^ out_data;
              out_index <= LAST_IDX;
              out_last  <= 1'b1;
              out_valid <= 1'b1;
`else
              done      <= 1'b1;
`endif
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - scoreboard bench for reg_dump_reader; honours REG_DUMP_CHECKSUM_EN
module tb_reg_dump_reader;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  index;
    logic        last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  rf_read_num;
  logic [63:0] rf_read_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  logic        start_1 = 1'b0;
  logic        abort_1 = 1'b0;
  logic [4:0]  rf_read_num_1;
  logic [63:0] rf_read_data_1;
  logic        out_valid_1;
  logic        out_ready_1 = 1'b1;
  logic [63:0] out_data_1;
  logic [4:0]  out_index_1;
  logic        out_last_1;
  logic        busy_1;
  logic        done_1;

  logic [63:0] rf [32];
  beat_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        expect_done = 1'b0;
  logic        rand_ready = 1'b0;
  logic        prev_stall = 1'b0;
  beat_t       prev_beat;

  always #5 clock = ~clock;

  assign rf_read_data   = rf[rf_read_num];
  assign rf_read_data_1 = rf[rf_read_num_1];

  reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .rf_read_num(rf_read_num), .rf_read_data(rf_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  reg_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) dut_one (
    .clock(clock), .reset(reset), .start(start_1), .abort(abort_1),
    .rf_read_num(rf_read_num_1), .rf_read_data(rf_read_data_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .out_data(out_data_1),
    .out_index(out_index_1), .out_last(out_last_1), .busy(busy_1), .done(done_1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_dump(input int first, input int last);
    logic [63:0] acc;
    acc = '0;
    for (int i = first; i <= last; i++) begin
`ifdef REG_DUMP_CHECKSUM_EN
      exp_q.push_back('{data: rf[i], index: 5'(i), last: 1'b0});
`else
      exp_q.push_back('{data: rf[i], index: 5'(i), last: (i == last)});
`endif
      acc = acc ^ rf[i];
    end
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back('{data: acc, index: 5'(last), last: 1'b1});
`endif
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock); #1;
      n++;
    end while ((exp_q.size() != 0 || busy || expect_done) && n < budget);
    check({name, "_complete"}, (n < budget), 1);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_beat(input string name, input int idx);
    int n;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!(out_valid && out_index == 5'(idx)) && n < 200);
    check({name, "_reached"}, (n < 200), 1);
  endtask

  always @(posedge clock) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard monitor: compares every accepted beat and the done pulse that must follow the last one.
  always @(negedge clock) begin
    if (!reset || abort) begin
      prev_stall = 1'b0;
      if (!reset) expect_done = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, prev_beat.data);
        check("stall_index_held", out_index, prev_beat.index);
        check("stall_last_held", out_last, prev_beat.last);
      end
      if (done || expect_done) begin
        check("done_pulse", done, expect_done);
        expect_done = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat_index", out_index, 5'h1f ^ out_index);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_index", out_index, e.index);
          check("beat_last", out_last, e.last);
          if (e.last) expect_done = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = '{data: out_data, index: out_index, last: out_last};
    end
  end

  initial begin
    int beats_1;
    int dones_1;
    for (int i = 0; i < 32; i++) rf[i] = 64'(i);

    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read_num", rf_read_num, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    push_dump(0, 31);
    pulse_start();
    wait_idle("full_dump", 300);

    rand_ready = 1'b1;
    push_dump(0, 31);
    pulse_start();
    wait_idle("stall_dump", 600);
    rand_ready = 1'b0;
    @(posedge clock); #2 out_ready = 1'b1;

    for (int i = 0; i < 10; i++)
      exp_q.push_back('{data: rf[i], index: 5'(i), last: 1'b0});
    pulse_start();
    wait_beat("abort_idx10", 10);
    abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_consumed", exp_q.size(), 0);
    repeat (4) @(posedge clock);
    push_dump(0, 31);
    pulse_start();
    wait_idle("after_abort", 300);

    rand_ready = 1'b1;
    push_dump(0, 31);
    pulse_start();
    wait_beat("reset_idx3", 3);
    start = 1'b1;
    repeat (3) @(posedge clock);
    #1 start = 1'b0;
    wait_beat("reset_idx6", 6);
    #3 reset = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_index", out_index, 0);
    check("async_rst_last", out_last, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_read_num", rf_read_num, 0);
    rand_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #2 out_ready = 1'b1;
    reset = 1'b1;
    repeat (8) @(posedge clock);
    #1 check("post_reset_busy", busy, 0);

    beats_1 = 0;
    dones_1 = 0;
    @(posedge clock); #1 start_1 = 1'b1;
    @(posedge clock); #1 start_1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (done_1) dones_1++;
      if (out_valid_1 && out_ready_1) begin
        if (beats_1 == 0) begin
          check("one_data", out_data_1, 64'h5);
          check("one_index", out_index_1, 5);
`ifdef REG_DUMP_CHECKSUM_EN
          check("one_last", out_last_1, 0);
`else
          check("one_last", out_last_1, 1);
`endif
        end
        beats_1++;
      end
    end
`ifdef REG_DUMP_CHECKSUM_EN
    check("one_beats", beats_1, 2);
`else
    check("one_beats", beats_1, 1);
`endif
    check("one_done", dones_1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
